// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions: default field parameters, the doubling step
// used by serial multipliers, and the sequencer state encoding.
package gf_pkg;
    localparam int GF_WIDTH = 8;
    localparam logic [GF_WIDTH:0] GF_POLY = 9'h11B;
    // Upper bound on field width supported by xtime.
    localparam int GF_MAXW = 32;
    localparam int GF_IDXW = $clog2(GF_MAXW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } gf_state_t;

    // Multiply by x modulo the polynomial; msb is the field width minus one and
    // poly_low the polynomial without its leading term. Callers truncate the result.
    function automatic logic [GF_MAXW-1:0] xtime(
        input logic [GF_MAXW-1:0] x,
        input logic [GF_MAXW-1:0] poly_low,
        input logic [GF_IDXW-1:0] msb
    );
        logic [GF_MAXW-1:0] r;
        r = x << 1;
        if (x[msb]) begin
            r = r ^ poly_low;
        end
        return r;
    endfunction
endpackage

// File: rtl/gf_dot_serial_if.sv
// Operand/result handshake bundle of the serial GF dot-product unit.
interface gf_dot_serial_if
    import gf_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH
);
    logic             i_start;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] in_1;
    logic [WIDTH-1:0] in_2;
    logic [WIDTH-1:0] out;
    logic             o_done;
    logic             o_busy;

    modport master (
        output i_start, i_valid, in_1, in_2,
        input  o_ready, out, o_done, o_busy
    );

    modport slave (
        input  i_start, i_valid, in_1, in_2,
        output o_ready, out, o_done, o_busy
    );
endinterface

// File: rtl/gf_mul_bitserial.sv
// Bit-serial GF(2^WIDTH) multiplier, b consumed MSB-first over WIDTH cycles.
// out/o_done present the finished product combinationally on the last step.
module gf_mul_bitserial
    import gf_pkg::*;
#(
    parameter int               WIDTH = GF_WIDTH,
    parameter logic [WIDTH:0]   POLY  = GF_POLY
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    output logic [WIDTH-1:0] out,
    output logic             o_done
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] p_reg;
    logic [WIDTH-1:0] p_next;
    logic [IW-1:0]    bit_idx_reg;
    logic             run_reg;
    logic             last;

    // b is shifted left each step, so its MSB is always b[WIDTH-1-bit_idx].
    always_comb begin
        p_next = WIDTH'(xtime(GF_MAXW'(p_reg), GF_MAXW'(POLY[WIDTH-1:0]), GF_IDXW'(WIDTH - 1)))
                 ^ (b_reg[WIDTH-1] ? a_reg : '0);
    end

    assign last   = run_reg && (bit_idx_reg == IW'(WIDTH - 1));
    assign out    = p_next;
    assign o_done = last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_reg       <= '0;
            b_reg       <= '0;
            p_reg       <= '0;
            bit_idx_reg <= '0;
            run_reg     <= 1'b0;
        end else if (i_start) begin
            a_reg       <= in_1;
            b_reg       <= in_2;
            p_reg       <= '0;
            bit_idx_reg <= '0;
            run_reg     <= 1'b1;
        end else if (run_reg) begin
            p_reg       <= p_next;
            b_reg       <= b_reg << 1;
            bit_idx_reg <= bit_idx_reg + IW'(1);
            if (last) begin
                run_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/gf_dot_serial.sv
// Sequential GF(2^WIDTH) dot product: LEN pairs accepted over valid/ready,
// each multiplied bit-serially and XOR-accumulated; result pulses on o_done.
module gf_dot_serial
    import gf_pkg::*;
#(
    parameter int               WIDTH = GF_WIDTH,
    parameter logic [WIDTH:0]   POLY  = GF_POLY,
    parameter int               LEN   = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    gf_dot_serial_if.slave bus
);
    localparam int CW = $clog2(LEN + 1);

    gf_state_t        state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] out_reg;
    logic             done_reg;
    logic             mul_start;
    logic [WIDTH-1:0] mul_out;
    logic             mul_done;

    gf_mul_bitserial #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (mul_start),
        .in_1    (bus.in_1),
        .in_2    (bus.in_2),
        .out     (mul_out),
        .o_done  (mul_done)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        mul_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.i_start) begin
                    cnt_next   = '0;
                    acc_next   = '0;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (bus.i_valid) begin
                    mul_start  = 1'b1;
                    state_next = MUL;
                end
            end
            MUL: begin
                if (mul_done) begin
                    acc_next   = acc_reg ^ mul_out;
                    cnt_next   = cnt_reg + CW'(1);
                    state_next = (cnt_reg == CW'(LEN - 1)) ? DONE : LOAD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // out/o_done are loaded on entry to DONE so they are valid in the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            out_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            done_reg  <= (state_next == DONE);
            if (state_next == DONE) begin
                out_reg <= acc_next;
            end
        end
    end

    assign bus.o_ready = (state_reg == LOAD);
    assign bus.o_busy  = (state_reg != IDLE);
    assign bus.out     = out_reg;
    assign bus.o_done  = done_reg;
endmodule

// File: doc/gf_dot_serial.md
# gf_dot_serial

Sequential GF(2^WIDTH) dot-product unit: accepts LEN operand pairs over a valid/ready handshake, multiplies each pair with a bit-serial shift-and-add multiplier, and XOR-accumulates the products. It sits directly upstream of `gf_add`. Its `out`/`o_done` pair drives `in_1`/`i_start` of that adder, so a dot product can be combined with a second field element. It serves the SDitH polynomial-evaluation and MPC share-computation datapaths.

## Interface
- `WIDTH`, 8, field element width in bits.
- `POLY`, 9'h11B, reduction polynomial x^8+x^4+x^3+x+1; WIDTH+1 bits, MSB must be 1.
- `LEN`, 16, number of terms per dot product; must be ≥1.
- `i_clk` in 1: clock. All logic is on the rising edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_start` in 1: begin a new dot product; sampled only in IDLE.
- `i_valid` in 1: the `in_1`/`in_2` pair is valid.
- `o_ready` out 1: the block accepts a pair this cycle.
- `in_1` in WIDTH: operand a.
- `in_2` in WIDTH: operand b.
- `out` out WIDTH: dot-product result, registered.
- `o_done` out 1: one-cycle pulse; `out` is valid in this cycle.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- **States:** IDLE, LOAD, MUL, DONE.
- **IDLE:**
  - `i_start`=1 clears `acc` and `cnt`, then moves to LOAD.
  - `i_valid` is ignored.
- **LOAD:**
  - `o_ready`=1.
  - On `i_valid`=1, latch a=`in_1` and b=`in_2`, clear `p` and `bit_idx`, then move to MUL.
  - With no valid, stay in LOAD indefinitely.
- **MUL:** runs exactly WIDTH cycles, processing b MSB-first.
  - Each cycle: `p` ← xtime(`p`) ^ (b[WIDTH-1-`bit_idx`] ? a : 0).
  - xtime(x) = (x<<1) ^ (x[WIDTH-1] ? POLY[WIDTH-1:0] : 0).
  - On the last cycle, `acc` ← `acc` ^ final `p` and `cnt` ← `cnt`+1.
  - Then go to DONE if `cnt` was LEN-1, otherwise to LOAD.
- **DONE:**
  - `out` ← `acc` and `o_done`=1 for this single cycle.
  - Next state is IDLE unconditionally.
  - `i_start` in DONE is ignored. It must be held into IDLE to take effect.
- **Output hold:** `out` keeps the last result until the next DONE or reset.
- **Ignored inputs:** `i_start` in LOAD/MUL/DONE is ignored, and so is `i_valid` outside LOAD. There is no abort.
- **Widths:** `cnt` is $clog2(LEN+1) bits and `bit_idx` is $clog2(WIDTH) bits. All arithmetic is carry-less (XOR).
- **Reset:**
  - `i_rst` at any time, including mid-MUL, forces IDLE.
  - Clears `acc`, `p`, `cnt`, `bit_idx`, a and b.
  - Output values under reset: `out`=0, `o_done`=0, `o_ready`=0, `o_busy`=0.
  - No partial result is emitted.

## Timing
- **Start:** `i_start` in cycle 0 puts the block in LOAD in cycle 1.
- **Per term:** 1 accept cycle + WIDTH MUL cycles.
  - Back-to-back throughput is one pair per WIDTH+1 cycles.
  - Term k is accepted no earlier than cycle 1+k·(WIDTH+1).
- **Result:** with `i_valid` held high, `o_done` is high in cycle 1+LEN·(WIDTH+1). This is 145 for the defaults and 37 for LEN=4.
- **Stalls:** each cycle of `i_valid` low in LOAD delays completion by exactly one cycle.
- **Outputs:**
  - `o_ready` and `o_busy` are decoded from state.
  - `out` and `o_done` are driven from registers, with no combinational input-to-output path.

## Structure
- **Shared package `gf_pkg`:**
  - default WIDTH and POLY constants.
  - `xtime` function.
  - state enum (IDLE, LOAD, MUL, DONE).
  - The package is shared with the other GF blocks.
- **Sub-module `gf_mul_bitserial`:**
  - Contains the a/b/`p`/`bit_idx` registers.
  - Ports: `i_clk`, `i_rst`, `i_start`, `in_1`, `in_2`, `out`, `o_done`; `o_done` pulses after WIDTH cycles.
  - The top level holds the FSM, `cnt` and `acc`.

## Test plan
- **Reset values:** assert `i_rst`; check `out`=0, `o_done`=0, `o_ready`=0, `o_busy`=0.
- **Single product:** LEN=1, pair (0x53, 0xCA) → `o_done` in cycle 10, `out`=0x01; also (0x02, 0x80) → 0x1B, which checks reduction.
- **Back-to-back accumulation:** LEN=4, pairs (0x57,0x83), (0x53,0xCA), (0x57,0x13), (0x00,0xFF) with `i_valid` constant → `o_done` in cycle 37, `out`=0xC1^0x01^0xFE^0x00=0x3E.
- **Stalls:** same LEN=4 vectors with 3 random idle cycles inserted in LOAD → `o_done` in cycle 40, `out`=0x3E; `i_valid` pulses in MUL and DONE are not consumed.
- **Reset mid-operation:** assert `i_rst` during MUL of term 2 → IDLE next cycle, no `o_done`. A fresh LEN=4 run must give 0x3E, proving `acc` was cleared.
- **Stray start:** pulse `i_start` during LOAD/MUL/DONE → ignored, result unchanged, `o_busy` stays high until IDLE. `out` holds 0x3E after `o_done` until the next run completes.
